// File: rtl/fetch_unit.sv
// fetch_unit: program counter plus a 2-entry instruction queue in front of a synchronous-read ROM.
// Optional feature macro FETCH_PERF_EN adds fetch/flush performance counters.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jump,
   input  logic              branch,
   input  logic              zero,
   input  logic [25:0]       jaddr,
   input  logic [15:0]       imm
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetches,
   output logic [15:0]       perf_flushes
`endif
);

   logic [31:0] pc_r;
   logic [31:0] tag_r;
   logic        inflight_r;
   logic [1:0]  count_r;
   logic        head_r;
   logic [31:0] q_instr_r [2];
   logic [31:0] q_pc_r    [2];

   logic        pop_s;
   logic        redirect_s;
   logic        issue_s;
   logic        wr_s;
   logic        tail_s;
   logic [31:0] pc_inc_s;
   logic [31:0] target_s;
   logic [2:0]  occ_s;

   assign instr     = q_instr_r[head_r];
   assign instr_pc  = q_pc_r[head_r];
   assign imem_addr = pc_r[ADDR_W-1:0];
   assign imem_req  = issue_s;

   // handshake, redirect target and fetch-issue decision
   always_comb begin
      instr_valid = 1'b0;
      pop_s       = 1'b0;
      redirect_s  = 1'b0;
      issue_s     = 1'b0;
      wr_s        = 1'b0;
      tail_s      = 1'b0;
      pc_inc_s    = 32'd0;
      target_s    = 32'd0;
      occ_s       = 3'd0;

      instr_valid = (count_r != 2'd0);
      pop_s       = instr_valid && instr_ready;
      pc_inc_s    = instr_pc + 32'd1;
      if (jump) begin
         target_s = {pc_inc_s[31:26], jaddr};
      end else begin
         target_s = pc_inc_s + {{16{imm[15]}}, imm};
      end
      redirect_s = pop_s && (jump || (branch && zero));

      // words already owned (queued or returning) minus the one leaving this cycle
      occ_s = {1'b0, count_r} + {2'b00, inflight_r};
      if (!reset && !redirect_s && (occ_s < (3'd2 + {2'b00, pop_s}))) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end

      wr_s   = inflight_r && !redirect_s;
      tail_s = head_r ^ count_r[0];
   end

   // PC, in-flight tag and instruction queue
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r       <= RESET_PC;
         tag_r      <= 32'd0;
         inflight_r <= 1'b0;
         count_r    <= 2'd0;
         head_r     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            q_instr_r[i] <= 32'd0;
            q_pc_r[i]    <= 32'd0;
         end
      end else if (redirect_s) begin
         pc_r       <= target_s;
         inflight_r <= 1'b0;
         count_r    <= 2'd0;
         head_r     <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            tag_r <= pc_r;
            pc_r  <= pc_r + 32'd1;
         end
         if (wr_s) begin
            q_instr_r[tail_s] <= imem_rdata;
            q_pc_r[tail_s]    <= tag_r;
         end
         if (pop_s) begin
            head_r <= ~head_r;
         end
         count_r <= count_r + {1'b0, wr_s} - {1'b0, pop_s};
      end
   end

`ifdef FETCH_PERF_EN
   // fetch and flush event counters, wrapping on overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetches <= 32'd0;
         perf_flushes <= 16'd0;
      end else begin
         if (issue_s) begin
            perf_fetches <= perf_fetches + 32'd1;
         end
         if (redirect_s) begin
            perf_flushes <= perf_flushes + 16'd1;
         end
      end
   end
`else
   // no performance counters in this build
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, stream-level reference model,
// directed sequences, a redirect vector table and randomized traffic.
module tb_fetch_unit;
   localparam int unsigned ADDR_W   = 4;
   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [3:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [25:0] jaddr;
   logic [15:0] imm;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetches;
   logic [15:0] perf_flushes;
   int unsigned m_fetches;
   int unsigned m_flushes;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jump(jump), .branch(branch), .zero(zero), .jaddr(jaddr), .imm(imm)
`ifdef FETCH_PERF_EN
      , .perf_fetches(perf_fetches), .perf_flushes(perf_flushes)
`endif
   );

   // synchronous ROM; garbage when not requested so unrequested data is visible
   logic [31:0] rom [16];
   always @(posedge clk) imem_rdata <= imem_req ? rom[imem_addr] : 32'hDEAD_BEEF;

   int total = 0;
   int bad   = 0;

   // reference model: next pc to be presented, next pc to be fetched, bubble countdown
   logic [31:0] exp_pc;
   logic [31:0] exp_fetch;
   int          post;

   typedef struct {
      logic [31:0] trig;
      logic        jump;
      logic        branch;
      logic        zero;
      logic [25:0] jaddr;
      logic [15:0] imm;
      logic [31:0] exp_next;
      int          exp_bub;
   } vec_t;
   vec_t vt [11];

   bit found;
   int bub;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      logic        pop;
      logic        redir;
      logic [31:0] nxt;
      logic [31:0] tgt;
      if (reset) begin
         chk("req_in_reset", {31'd0, imem_req}, 32'd0);
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
         post      = 3;
`ifdef FETCH_PERF_EN
         m_fetches = 0;
         m_flushes = 0;
`endif
      end else begin
         if (post == 3 || post == 2) begin
            chk("bubble_valid", {31'd0, instr_valid}, 32'd0);
            chk("refetch_req", {31'd0, imem_req}, 32'd1);
         end else if (post == 1) begin
            chk("refill_valid", {31'd0, instr_valid}, 32'd1);
         end
         if (post > 0) post--;
         if (instr_valid) begin
            chk("head_pc", instr_pc, exp_pc);
            chk("head_instr", instr, rom[exp_pc[3:0]]);
         end
`ifdef FETCH_PERF_EN
         chk("perf_fetches", perf_fetches, m_fetches);
         chk("perf_flushes", {16'd0, perf_flushes}, {16'd0, m_flushes[15:0]});
`endif
         pop   = instr_valid && instr_ready;
         redir = pop && (jump || (branch && zero));
         nxt   = exp_pc + 32'd1;
         if (jump) tgt = {nxt[31:26], jaddr};
         else      tgt = nxt + {{16{imm[15]}}, imm};
         if (redir) begin
            chk("req_on_redirect", {31'd0, imem_req}, 32'd0);
         end else if (imem_req) begin
            chk("fetch_addr", {28'd0, imem_addr}, {28'd0, exp_fetch[3:0]});
            exp_fetch = exp_fetch + 32'd1;
         end
`ifdef FETCH_PERF_EN
         if (imem_req) m_fetches++;
         if (redir) m_flushes++;
`endif
         if (redir) begin
            exp_pc    = tgt;
            exp_fetch = tgt;
            post      = 3;
         end else if (pop) begin
            exp_pc = nxt;
         end
      end
   endtask

   // inputs are set at the negedge before calling; checks run 1 time unit later
   task automatic tick();
      #1;
      check_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_after_reset();
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", {28'd0, imem_addr}, {28'd0, RESET_PC[3:0]});
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
      vt[0]  = '{32'd4,        1'b0, 1'b1, 1'b0, 26'd0,       16'hFFFA, 32'd5,        0};
      vt[1]  = '{32'd5,        1'b0, 1'b1, 1'b1, 26'd0,       16'hFFFA, 32'd0,        2};
      vt[2]  = '{32'd3,        1'b1, 1'b1, 1'b1, 26'd9,       16'h0000, 32'd9,        2};
      vt[3]  = '{32'd11,       1'b0, 1'b1, 1'b0, 26'd0,       16'h0010, 32'd12,       0};
      vt[4]  = '{32'd13,       1'b0, 1'b1, 1'b1, 26'd0,       16'h0004, 32'd18,       2};
      vt[5]  = '{32'd20,       1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 16'h0000, 32'h03FFFFFF, 2};
      vt[6]  = '{32'h03FFFFFF, 1'b1, 1'b0, 1'b0, 26'd5,       16'h0000, 32'h04000005, 2};
      vt[7]  = '{32'h04000006, 1'b0, 1'b1, 1'b1, 26'd0,       16'h8000, 32'h03FF8007, 2};
      vt[8]  = '{32'h03FF8008, 1'b0, 1'b1, 1'b1, 26'd0,       16'hFFFF, 32'h03FF8008, 2};
      vt[9]  = '{32'h03FF8008, 1'b0, 1'b0, 1'b1, 26'h1234,    16'h0005, 32'h03FF8009, 0};
      vt[10] = '{32'h03FF800A, 1'b0, 1'b1, 1'b1, 26'd0,       16'hFFFD, 32'h03FF8008, 2};

      reset = 1'b1; instr_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
      jaddr = 26'd0; imm = 16'd0; post = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
`ifdef FETCH_PERF_EN
      m_fetches = 0; m_flushes = 0;
`endif
      @(negedge clk);
      tick(); tick();
      reset = 1'b0;
      instr_ready = 1'b1;
      check_after_reset();
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);

      // sustained throughput, pc crosses 16 so the ROM index wraps
      for (int c = 0; c < 22; c++) begin
         if (c >= 2) begin
            #1;
            chk("throughput_valid", {31'd0, instr_valid}, 32'd1);
         end
         tick();
      end

      // consumer stall for 5 cycles
      instr_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         if (s >= 1) begin
            #1;
            chk("stall_req", {31'd0, imem_req}, 32'd0);
         end
         tick();
      end
      instr_ready = 1'b1;
      for (int c = 0; c < 10; c++) tick();

      // reset with a full queue
      instr_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instr_ready = 1'b1;
      check_after_reset();
      for (int c = 0; c < 8; c++) tick();

      // reset while a fetch is returning
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_after_reset();
      for (int c = 0; c < 8; c++) tick();

      // redirect vector table
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int v = 0; v < 11; v++) begin
         found = 1'b0;
         for (int w = 0; w < 100 && !found; w++) begin
            instr_ready = 1'b1;
            if (instr_valid && instr_pc == vt[v].trig) begin
               found  = 1'b1;
               jump   = vt[v].jump;
               branch = vt[v].branch;
               zero   = vt[v].zero;
               jaddr  = vt[v].jaddr;
               imm    = vt[v].imm;
               tick();
               jump = 1'b0; branch = 1'b0; zero = 1'b0; jaddr = 26'd0; imm = 16'd0;
               bub = 0;
               while (!instr_valid && bub < 10) begin
                  bub++;
                  tick();
               end
               chk("vec_next_pc", instr_pc, vt[v].exp_next);
               chk("vec_bubbles", bub, vt[v].exp_bub);
            end else begin
               tick();
            end
         end
         chk("vec_trigger_seen", {31'd0, found}, 32'd1);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         instr_ready = ($urandom_range(0, 9) < 7);
         jump        = ($urandom_range(0, 9) == 0);
         branch      = ($urandom_range(0, 5) == 0);
         zero        = ($urandom_range(0, 1) == 1);
         jaddr       = 26'($urandom());
         imm         = 16'($urandom());
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
